// File: rtl/seg_pattern_decoder.sv
// seg_pattern_decoder
//   Receive side of a 7-segment display path. Samples the segment lines,
//   waits for a pattern to be stable for STABLE_CYCLES consecutive samples,
//   decodes it back to a hex digit and offers it on a valid/ready port.
//   Blank (all off) and illegal patterns are flagged instead of decoded.
//
//   Optional build macro: SEG_ACTIVE_LOW_EN
//     defined   -> segment inputs are inverted before sampling (common-anode)
//     undefined -> segment inputs are active-high and used as-is
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (priority over enable)
//   enable     in   0 holds the decoder idle; clears state, counter, valid, blank
//   a..g       in   segment lines, pattern = {a,b,c,d,e,f,g}
//   value      out  [3:0] decoded digit, stable while valid
//   valid      out  value available
//   ready      in   consumer takes value when valid & ready at an edge
//   blank      out  level, last accepted pattern was all-off
//   err        out  one-cycle pulse, accepted pattern is illegal
//   err_count  out  [7:0] saturating count of err pulses
//   overflow   out  sticky, a legal symbol was dropped because valid & !ready
//   fsm_state  out  [1:0] debug view of the FSM (0 idle, 1 settle, 2 locked)
//
// Handshake: a beat transfers on every rising edge where valid & ready are
// both high; valid never drops without a transfer except on reset or enable=0.

module seg_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic [3:0] value,
  output logic       valid,
  input  logic       ready,
  output logic       blank,
  output logic       err,
  output logic [7:0] err_count,
  output logic       overflow,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [6:0]       seg_in;
  logic [6:0]       smp;
  logic [6:0]       acc;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             dec_legal;
  logic [3:0]       dec_val;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_in = ~{a, b, c, d, e, f, g};
`else
  assign seg_in = {a, b, c, d, e, f, g};
`endif

  assign fsm_state = state;

  // Decode of the live input; it is only used on the accepting edge, where
  // the input equals the settled sample by construction.
  always_comb begin
    dec_legal = 1'b1;
    dec_val   = 4'h0;
    case (seg_in)
      7'h7E: dec_val = 4'h0;
      7'h30: dec_val = 4'h1;
      7'h6D: dec_val = 4'h2;
      7'h79: dec_val = 4'h3;
      7'h33: dec_val = 4'h4;
      7'h5B: dec_val = 4'h5;
      7'h5F: dec_val = 4'h6;
      7'h70: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h7B: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h1F: dec_val = 4'hB;
      7'h4E: dec_val = 4'hC;
      7'h3D: dec_val = 4'hD;
      7'h4F: dec_val = 4'hE;
      7'h47: dec_val = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:   state_nxt = SETTLE;
      SETTLE: begin
        if ((cnt == CNT_MAX) && (seg_in == smp)) begin
          accept    = 1'b1;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (seg_in != acc) state_nxt = SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sampler and stability counter; the counter saturates so a held pattern
  // is seen as "still stable" without wrapping back into a fresh settle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp <= 7'h00;
      cnt <= '0;
    end else begin
      smp <= seg_in;
      if (!enable || (seg_in != smp)) cnt <= '0;
      else if (cnt != CNT_MAX)        cnt <= cnt + CNT_W'(1);
    end
  end

  // Output datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= 7'h00;
      value     <= 4'h0;
      valid     <= 1'b0;
      blank     <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'h00;
      overflow  <= 1'b0;
    end else if (!enable) begin
      valid <= 1'b0;
      blank <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      if (accept) begin
        acc   <= seg_in;
        blank <= 1'b0;
        if (dec_legal) begin
          if (!valid || ready) begin
            value <= dec_val;
            valid <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end else if (seg_in == 7'h00) begin
          blank <= 1'b1;
        end else begin
          err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Bench for seg_pattern_decoder: directed scenarios followed by randomized
// segment streams, every cycle compared against a run-length reference model.

module tb_seg_pattern_decoder;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       ready = 1'b0;
  logic [6:0] seg_raw = 7'h00;
  logic [3:0] value;
  logic       valid, blank, err, overflow;
  logic [7:0] err_count;
  logic [1:0] fsm_state;

  int n_vec = 0;
  int n_err = 0;

  // clock/reset block
  always #5 clk = ~clk;

  seg_pattern_decoder #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .a(seg_raw[6]), .b(seg_raw[5]), .c(seg_raw[4]), .d(seg_raw[3]),
    .e(seg_raw[2]), .f(seg_raw[1]), .g(seg_raw[0]),
    .value(value), .valid(valid), .ready(ready), .blank(blank), .err(err),
    .err_count(err_count), .overflow(overflow), .fsm_state(fsm_state)
  );

  // Reference model: a pattern is accepted once it has been seen on S+1
  // consecutive enabled edges since the decoder last started looking.
  logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [3:0] m_value;
  logic       m_valid, m_blank, m_err, m_ovf;
  logic [7:0] m_errcnt;
  logic [6:0] m_prev, m_pat;
  int         m_run;
  bit         m_active, m_locked;

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [6:0] raw, input logic en, input logic rdy, input logic rn);
    logic [6:0] s;
    bit acc;
    int idx;
    logic old_valid;
`ifdef SEG_ACTIVE_LOW_EN
    s = ~raw;
`else
    s = raw;
`endif
    if (!rn) begin
      m_value = 0; m_valid = 0; m_blank = 0; m_err = 0; m_ovf = 0; m_errcnt = 0;
      m_prev = 0; m_pat = 0; m_run = 1; m_active = 0; m_locked = 0;
      return;
    end
    m_run  = (s == m_prev) ? ((m_run < 100) ? m_run + 1 : m_run) : 1;
    m_prev = s;
    if (!en) begin
      m_active = 0; m_locked = 0; m_valid = 0; m_blank = 0; m_err = 0; m_run = 1;
      return;
    end
    m_err = 0;
    acc = m_active && !m_locked && (m_run == S + 1);
    if (m_active && m_locked && s != m_pat) m_locked = 0;
    old_valid = m_valid;
    if (m_valid && rdy) m_valid = 0;
    if (acc) begin
      m_locked = 1;
      m_pat    = s;
      m_blank  = 0;
      idx = lookup(s);
      if (idx >= 0) begin
        if (!old_valid || rdy) begin
          m_value = 4'(idx);
          m_valid = 1;
        end else m_ovf = 1;
      end else if (s == 7'h00) m_blank = 1;
      else begin
        m_err = 1;
        if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 1;
      end
    end
    m_active = 1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs and compare all outputs after the edge
  task automatic cyc(input logic [6:0] raw, input logic en, input logic rdy, input logic rn);
    seg_raw = raw; enable = en; ready = rdy; rst_n = rn;
    model_step(raw, en, rdy, rn);
    @(posedge clk);
    #1;
    check("value", value, m_value);
    check("valid", valid, m_valid);
    check("blank", blank, m_blank);
    check("err", err, m_err);
    check("err_count", err_count, m_errcnt);
    check("overflow", overflow, m_ovf);
  endtask

  function automatic logic [6:0] phys(input logic [6:0] s);
`ifdef SEG_ACTIVE_LOW_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  task automatic do_reset();
    cyc(phys(7'h00), 1'b0, 1'b0, 1'b0);
    cyc(phys(7'h00), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hold(input logic [6:0] s, input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(phys(s), 1'b1, rdy, 1'b1);
  endtask

  initial begin
    int err_seen;
    do_reset();
    check("rst_valid", valid, 0);
    check("rst_errcnt", err_count, 0);
    check("rst_state", fsm_state, 0);

    // 1: steady 6D -> one beat of value 2 after edge 4
    hold(7'h6D, 4, 1'b1);
    check("t1_pre", valid, 0);
    hold(7'h6D, 1, 1'b1);
    check("t1_valid", valid, 1);
    check("t1_value", value, 2);
    hold(7'h6D, 10, 1'b1);
    check("t1_single", valid, 0);

    // 2: short 5B glitch, then 47 steady
    do_reset();
    hold(7'h5B, 2, 1'b1);
    hold(7'h47, 5, 1'b1);
    check("t2_value", value, 4'hF);
    check("t2_valid", valid, 1);
    hold(7'h47, 5, 1'b1);
    check("t2_errcnt", err_count, 0);

    // 3: overflow while consumer stalls
    do_reset();
    hold(7'h30, 5, 1'b0);
    check("t3_value", value, 1);
    hold(7'h7F, 6, 1'b0);
    check("t3_ovf", overflow, 1);
    check("t3_held", value, 1);
    check("t3_valid_hold", valid, 1);
    hold(7'h7F, 1, 1'b1);
    check("t3_drop", valid, 0);

    // 4: illegal pattern, then saturation of err_count
    do_reset();
    err_seen = 0;
    for (int i = 0; i < 5; i++) begin
      hold(7'h01, 1, 1'b1);
      if (err) err_seen++;
    end
    check("t4_pulse", err_seen, 1);
    hold(7'h01, 3, 1'b1);
    check("t4_count", err_count, 1);
    for (int i = 0; i < 300; i++) hold((i % 2) ? 7'h01 : 7'h02, 5, 1'b1);
    check("t4_sat", err_count, 8'hFF);

    // 5: blank, then enable drop
    do_reset();
    hold(7'h30, 5, 1'b1);
    hold(7'h00, 5, 1'b1);
    check("t5_blank", blank, 1);
    check("t5_valid", valid, 0);
    cyc(phys(7'h00), 1'b0, 1'b1, 1'b1);
    check("t5_idle", fsm_state, 0);
    check("t5_blank_clr", blank, 0);

`ifdef SEG_ACTIVE_LOW_EN
    // 6: common-anode inputs
    do_reset();
    for (int i = 0; i < 5; i++) cyc(7'h01, 1'b1, 1'b1, 1'b1);
    check("t6_value", value, 0);
    check("t6_valid", valid, 1);
    for (int i = 0; i < 5; i++) cyc(7'h7F, 1'b1, 1'b1, 1'b1);
    check("t6_blank", blank, 1);
`endif

    // randomized segment streams
    do_reset();
    for (int k = 0; k < 700; k++) begin
      logic [6:0] s;
      int r, n;
      r = $urandom_range(0, 9);
      if (r < 6)       s = codes[$urandom_range(0, 15)];
      else if (r == 6) s = 7'h00;
      else if (r == 7) s = 7'h01;
      else             s = 7'($urandom_range(0, 127));
      n = $urandom_range(1, 7);
      for (int j = 0; j < n; j++)
        cyc(phys(s), ($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 300) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
